arcade_input_ctrl: RTL

- Upstream input stage for the Rush'n Attack core.
- Merges hps_io PS/2 key events and the two 16-bit joystick words (USB or DB15-remapped) into the game-core input vectors INP0/INP1/INP2.
- Adds edge-safe PS/2 event decode, optional SOCD cleaning, upright/cocktail P2→P1 merge, and a fixed-width coin pulse generator, so the core sees clean, registered, active-high controls.

---
 rtl/arcade_input_pkg.sv | 117 +++++++++++
 rtl/arcade_input_ctrl_ps2_key_latch.sv | 53 +++++
 rtl/arcade_input_ctrl.sv | 96 +++++++++
 3 files changed

// File: rtl/arcade_input_pkg.sv
// Shared definitions for the Rush'n Attack input stage: PS/2 scancodes,
// joystick bit positions, key-vector indices and control-word helpers.
package arcade_input_pkg;

   localparam logic [8:0] SC_UP      = 9'h075;
   localparam logic [8:0] SC_DOWN    = 9'h072;
   localparam logic [8:0] SC_LEFT    = 9'h06B;
   localparam logic [8:0] SC_RIGHT   = 9'h074;
   localparam logic [8:0] SC_TRIG1   = 9'h029;
   localparam logic [8:0] SC_TRIG2   = 9'h014;
   localparam logic [8:0] SC_F1      = 9'h005;
   localparam logic [8:0] SC_F2      = 9'h006;
   localparam logic [8:0] SC_START1  = 9'h016;
   localparam logic [8:0] SC_START2  = 9'h01E;
   localparam logic [8:0] SC_COIN1   = 9'h02E;
   localparam logic [8:0] SC_COIN2   = 9'h036;
   localparam logic [8:0] SC_UP2     = 9'h02D;
   localparam logic [8:0] SC_DOWN2   = 9'h02B;
   localparam logic [8:0] SC_LEFT2   = 9'h023;
   localparam logic [8:0] SC_RIGHT2  = 9'h034;
   localparam logic [8:0] SC_TRIG1_2 = 9'h01C;
   localparam logic [8:0] SC_TRIG2_2 = 9'h01B;

   localparam int JB_R      = 0;
   localparam int JB_L      = 1;
   localparam int JB_D      = 2;
   localparam int JB_U      = 3;
   localparam int JB_TRIG1  = 4;
   localparam int JB_TRIG2  = 5;
   localparam int JB_START1 = 6;
   localparam int JB_START2 = 7;
   localparam int JB_COIN   = 8;

   localparam int NUM_KEYS = 18;

   localparam logic [4:0] K_UP      = 5'd0;
   localparam logic [4:0] K_DOWN    = 5'd1;
   localparam logic [4:0] K_LEFT    = 5'd2;
   localparam logic [4:0] K_RIGHT   = 5'd3;
   localparam logic [4:0] K_TRIG1   = 5'd4;
   localparam logic [4:0] K_TRIG2   = 5'd5;
   localparam logic [4:0] K_F1      = 5'd6;
   localparam logic [4:0] K_F2      = 5'd7;
   localparam logic [4:0] K_START1  = 5'd8;
   localparam logic [4:0] K_START2  = 5'd9;
   localparam logic [4:0] K_COIN1   = 5'd10;
   localparam logic [4:0] K_COIN2   = 5'd11;
   localparam logic [4:0] K_UP2     = 5'd12;
   localparam logic [4:0] K_DOWN2   = 5'd13;
   localparam logic [4:0] K_LEFT2   = 5'd14;
   localparam logic [4:0] K_RIGHT2  = 5'd15;
   localparam logic [4:0] K_TRIG1_2 = 5'd16;
   localparam logic [4:0] K_TRIG2_2 = 5'd17;
   localparam logic [4:0] K_NONE    = 5'd31;

   typedef struct packed {
      logic trig2;
      logic trig1;
      logic left;
      logic down;
      logic right;
      logic up;
   } ctl_t;

   typedef enum logic {
      ST_WAIT  = 1'b0,
      ST_ARMED = 1'b1
   } latch_state_t;

   // Directions match on the low byte so both plain and E0-prefixed arrows work.
   function automatic logic [4:0] key_index(input logic [8:0] code);
      logic [4:0] idx;
      idx = K_NONE;
      case (code[7:0])
         SC_UP[7:0]:    idx = K_UP;
         SC_DOWN[7:0]:  idx = K_DOWN;
         SC_LEFT[7:0]:  idx = K_LEFT;
         SC_RIGHT[7:0]: idx = K_RIGHT;
         default:       idx = K_NONE;
      endcase
      if (idx == K_NONE) begin
         case (code)
            SC_TRIG1:   idx = K_TRIG1;
            SC_TRIG2:   idx = K_TRIG2;
            SC_F1:      idx = K_F1;
            SC_F2:      idx = K_F2;
            SC_START1:  idx = K_START1;
            SC_START2:  idx = K_START2;
            SC_COIN1:   idx = K_COIN1;
            SC_COIN2:   idx = K_COIN2;
            SC_UP2:     idx = K_UP2;
            SC_DOWN2:   idx = K_DOWN2;
            SC_LEFT2:   idx = K_LEFT2;
            SC_RIGHT2:  idx = K_RIGHT2;
            SC_TRIG1_2: idx = K_TRIG1_2;
            SC_TRIG2_2: idx = K_TRIG2_2;
            default:    idx = K_NONE;
         endcase
      end
      return idx;
   endfunction

   function automatic ctl_t socd_clean(input ctl_t c);
      ctl_t r;
      r = c;
      if (c.up && c.down) begin
         r.up   = 1'b0;
         r.down = 1'b0;
      end
      if (c.left && c.right) begin
         r.left  = 1'b0;
         r.right = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/arcade_input_ctrl_ps2_key_latch.sv
// PS/2 event capture: arms one clock after reset release, then turns each
// toggle change of ps2_key[10] into a press/release of the decoded key latch.
//
// state    | meaning
// ST_WAIT  | just out of reset; sample toggle, no decode
// ST_ARMED | toggle change = one key event
module ps2_key_latch
   import arcade_input_pkg::*;
(
   input  logic                clk_sys,
   input  logic                reset_n,
   input  logic [10:0]         ps2_key,
   output logic [NUM_KEYS-1:0] keys
);

   latch_state_t        state;
   latch_state_t        state_nxt;
   logic                prev_tog;
   logic                evt;
   logic [4:0]          idx;
   logic [NUM_KEYS-1:0] keys_nxt;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_WAIT;
         prev_tog <= 1'b0;
         keys     <= '0;
      end else begin
         state    <= state_nxt;
         prev_tog <= ps2_key[10];
         keys     <= keys_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      evt       = 1'b0;
      case (state)
         ST_WAIT:  state_nxt = ST_ARMED;
         ST_ARMED: evt = (ps2_key[10] != prev_tog);
         default:  state_nxt = ST_WAIT;
      endcase
   end

   always_comb begin
      keys_nxt = keys;
      idx      = key_index(ps2_key[8:0]);
      if (evt && (idx != K_NONE)) begin
         keys_nxt[idx] = ps2_key[9];
      end
   end

endmodule

// File: rtl/arcade_input_ctrl.sv
// Input stage top: merges PS/2 keys and two joysticks into INP0/INP1/INP2
// with optional SOCD cleaning, upright P2->P1 merge and a fixed coin pulse.
module arcade_input_ctrl
   import arcade_input_pkg::*;
#(
   parameter int COIN_CYC   = 2400000,
   parameter int SOCD_CLEAR = 1
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic [10:0] ps2_key,
   input  logic [15:0] joy1,
   input  logic [15:0] joy2,
   input  logic        cabinet,
   output logic [5:0]  inp0,
   output logic [5:0]  inp1,
   output logic [2:0]  inp2
);

   localparam int CW = $clog2(COIN_CYC + 1);

   logic [NUM_KEYS-1:0] keys;
   ctl_t                kp1, kp2, jp1, jp2;
   ctl_t                p1_raw, p2_raw, p1_cln, p2_cln;
   ctl_t                p1_q, p2_q;
   logic                start1, start2, coin_raw;
   logic [1:0]          start_q;
   logic                coin_q, coin_q2, coin_rise;
   logic [CW-1:0]       coin_cnt;
   logic                unused_joy_bits;

   assign unused_joy_bits = &{1'b0, joy1[15:9], joy2[15:9]};

   ps2_key_latch u_key_latch (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .ps2_key (ps2_key),
      .keys    (keys)
   );

   always_comb begin
      kp1 = '{trig2: keys[K_TRIG2],   trig1: keys[K_TRIG1],
              left:  keys[K_LEFT],    down:  keys[K_DOWN],
              right: keys[K_RIGHT],   up:    keys[K_UP]};
      kp2 = '{trig2: keys[K_TRIG2_2], trig1: keys[K_TRIG1_2],
              left:  keys[K_LEFT2],   down:  keys[K_DOWN2],
              right: keys[K_RIGHT2],  up:    keys[K_UP2]};
      jp1 = '{trig2: joy1[JB_TRIG2],  trig1: joy1[JB_TRIG1],
              left:  joy1[JB_L],      down:  joy1[JB_D],
              right: joy1[JB_R],      up:    joy1[JB_U]};
      jp2 = '{trig2: joy2[JB_TRIG2],  trig1: joy2[JB_TRIG1],
              left:  joy2[JB_L],      down:  joy2[JB_D],
              right: joy2[JB_R],      up:    joy2[JB_U]};

      p2_raw = kp2 | jp2;
      p1_raw = kp1 | jp1 | (cabinet ? ctl_t'('0) : p2_raw);

      p1_cln = (SOCD_CLEAR != 0) ? socd_clean(p1_raw) : p1_raw;
      p2_cln = (SOCD_CLEAR != 0) ? socd_clean(p2_raw) : p2_raw;

      start1   = keys[K_F1] | keys[K_START1] | joy1[JB_START1] | joy2[JB_START1];
      start2   = keys[K_F2] | keys[K_START2] | joy1[JB_START2] | joy2[JB_START2];
      coin_raw = keys[K_F1] | keys[K_F2] | keys[K_COIN1] | keys[K_COIN2]
               | joy1[JB_COIN] | joy2[JB_COIN];
   end

   assign coin_rise = coin_q & ~coin_q2;

   // Coin history resets high so a coin held through reset is not an edge.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         p1_q     <= '0;
         p2_q     <= '0;
         start_q  <= '0;
         coin_q   <= 1'b1;
         coin_q2  <= 1'b1;
         coin_cnt <= '0;
      end else begin
         p1_q     <= p1_cln;
         p2_q     <= p2_cln;
         start_q  <= {start2, start1};
         coin_q   <= coin_raw;
         coin_q2  <= coin_q;
         if (coin_cnt != '0) begin
            coin_cnt <= coin_cnt - CW'(1);
         end else if (coin_rise) begin
            coin_cnt <= CW'(COIN_CYC);
         end
      end
   end

   assign inp0 = p1_q;
   assign inp1 = p2_q;
   assign inp2 = {(coin_cnt != '0), start_q};

endmodule
